// File: rtl/queue_uart_tx.sv
// queue_uart_tx: drains the byte queue and sends each byte as an 8N1 UART frame
module queue_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W = 8
) (
    input  logic              Clk_i,
    input  logic              Rst_i,
    input  logic              Enable_i,
    input  logic              q_empty_i,
    input  logic [DATA_W-1:0] q_data_i,
    output logic              q_en_o,
    output logic              q_rw_o,
    output logic              tx_o,
    output logic              busy_o
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;

    state_t            state, n_state;
    logic [BW-1:0]     baud, n_baud;
    logic [CW-1:0]     bit_cnt, n_bit;
    logic [DATA_W-1:0] sh, n_sh;
    logic              n_tx;
    logic              baud_done;

    assign baud_done = (baud == BAUD_LAST);

    // next-state logic; outputs are derived from the next state so they can be registered
    always_comb begin
        n_state = state;
        n_baud  = baud;
        n_bit   = bit_cnt;
        n_sh    = sh;
        case (state)
            IDLE:    n_state = (Enable_i && !q_empty_i) ? REQ : IDLE;
            REQ:     n_state = LOAD;
            LOAD: begin
                n_sh    = q_data_i;
                n_baud  = '0;
                n_state = START;
            end
            START: begin
                n_baud  = baud_done ? '0 : baud + BW'(1);
                n_bit   = '0;
                n_state = baud_done ? DATA : START;
            end
            DATA: begin
                n_baud  = baud_done ? '0 : baud + BW'(1);
                n_sh    = baud_done ? sh >> 1 : sh;
                n_bit   = baud_done ? ((bit_cnt == BIT_LAST) ? '0 : bit_cnt + CW'(1)) : bit_cnt;
                n_state = (baud_done && bit_cnt == BIT_LAST) ? STOP : DATA;
            end
            STOP: begin
                n_baud  = baud_done ? '0 : baud + BW'(1);
                n_state = baud_done ? IDLE : STOP;
            end
            default: n_state = IDLE;
        endcase
        n_tx = (n_state == START) ? 1'b0 : (n_state == DATA) ? n_sh[0] : 1'b1;
    end

    // state, counters, shift register and registered outputs
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            q_en_o  <= 1'b0;
            q_rw_o  <= 1'b0;
        end else begin
            state   <= n_state;
            baud    <= n_baud;
            bit_cnt <= n_bit;
            sh      <= n_sh;
            tx_o    <= n_tx;
            busy_o  <= (n_state != IDLE);
            q_en_o  <= (n_state == REQ);
            q_rw_o  <= (n_state == REQ);
        end
    end
endmodule

// File: tb/tb_queue_uart_tx.sv
// tb_queue_uart_tx: directed and random frames checked against a bit-level frame model
module tb_queue_uart_tx;
    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       q_empty;
    logic [7:0] q_data = 8'h00;
    logic       q_en, q_rw, tx, busy;

    logic [7:0] mem [0:63];
    int n_push = 0;
    int n_pop = 0;
    int n_strobe = 0;
    int total = 0;
    int bad = 0;

    queue_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .Clk_i(clk), .Rst_i(rst), .Enable_i(enable), .q_empty_i(q_empty),
        .q_data_i(q_data), .q_en_o(q_en), .q_rw_o(q_rw), .tx_o(tx), .busy_o(busy)
    );

    always #5 clk = ~clk;

    assign q_empty = (n_push == n_pop);

    // queue model: a read at an edge with en&rw presents the head byte for the next cycle
    always @(posedge clk) begin
        if (q_en && q_rw && n_push != n_pop) begin
            q_data <= mem[n_pop[5:0]];
            n_pop  <= n_pop + 1;
        end
    end

    // strobe counter
    always @(posedge clk) if (q_en) n_strobe <= n_strobe + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        mem[n_push[5:0]] = d;
        n_push = n_push + 1;
    endtask

    // expected line level for cycle i of a frame carrying byte d
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int j;
        j = i / CPB;
        return (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
    endfunction

    // waits for a strobe; returns the number of cycles it took (0 if never seen)
    task automatic wait_strobe(output int n);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (q_en === 1'b1) begin
                n = k;
                break;
            end
            check("pre_strobe_tx", tx, 1);
        end
        check("strobe_seen", n != 0, 1);
    endtask

    // called at the REQ cycle; checks the rest of the frame with optional enable drop / reset
    task automatic check_frame(input logic [7:0] d, input int drop_at, input int rst_at);
        bit aborted = 0;
        check("req_rw", q_rw, 1);
        check("req_busy", busy, 1);
        check("req_tx", tx, 1);
        tick();
        check("load_en", q_en, 0);
        check("load_rw", q_rw, 0);
        check("load_tx", tx, 1);
        check("load_busy", busy, 1);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            check("frame_tx", tx, exp_bit(d, i));
            check("frame_busy", busy, 1);
            check("frame_en", q_en, 0);
            if (i == drop_at) enable = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                tick();
                check("rst_tx", tx, 1);
                check("rst_busy", busy, 0);
                check("rst_en", q_en, 0);
                rst = 1'b0;
                aborted = 1;
                break;
            end
        end
        if (!aborted) begin
            tick();
            check("post_busy", busy, 0);
            check("post_tx", tx, 1);
        end
    endtask

    initial begin
        int n;
        int s0;
        logic [7:0] r0, r1;
        push(8'd115);
        // reset held with a byte waiting and enable high
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_tx", tx, 1);
            check("reset_busy", busy, 0);
            check("reset_en", q_en, 0);
            check("reset_rw", q_rw, 0);
        end
        check("reset_no_strobe", n_strobe, 0);
        rst = 1'b0;
        // single byte
        wait_strobe(n);
        check("single_latency", n, 1);
        check_frame(8'd115, -1, -1);
        s0 = n_strobe;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("drained_tx", tx, 1);
        end
        check("single_strobes", n_strobe - s0, 0);
        check("single_total_strobes", n_strobe, 1);
        // two bytes back to back
        push(8'd115);
        push(8'd123);
        s0 = n_strobe;
        wait_strobe(n);
        check_frame(8'd115, -1, -1);
        wait_strobe(n);
        check("b2b_gap", n, 1);
        check_frame(8'd123, -1, -1);
        repeat (10) tick();
        check("b2b_strobes", n_strobe - s0, 2);
        // random bytes back to back
        s0 = n_strobe;
        for (int k = 0; k < 4; k++) push(8'($urandom_range(0, 255)));
        for (int k = 0; k < 4; k++) begin
            wait_strobe(n);
            check_frame(mem[(n_push - 4 + k) % 64], -1, -1);
        end
        repeat (5) tick();
        check("rand_strobes", n_strobe - s0, 4);
        // empty queue
        s0 = n_strobe;
        for (int k = 0; k < 100; k++) begin
            tick();
            check("empty_tx", tx, 1);
            check("empty_busy", busy, 0);
            check("empty_en", q_en, 0);
        end
        check("empty_strobes", n_strobe - s0, 0);
        // enable dropped during data bit 3
        r0 = 8'($urandom_range(0, 255));
        push(8'd115);
        push(r0);
        s0 = n_strobe;
        wait_strobe(n);
        check_frame(8'd115, 4 * CPB + 1, -1);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("disabled_tx", tx, 1);
            check("disabled_busy", busy, 0);
        end
        check("disabled_strobes", n_strobe - s0, 1);
        enable = 1'b1;
        wait_strobe(n);
        check("reenable_latency", n, 1);
        check_frame(r0, -1, -1);
        // reset during data bit 5
        r0 = 8'($urandom_range(0, 255));
        r1 = 8'($urandom_range(0, 255));
        push(r0);
        push(r1);
        s0 = n_strobe;
        wait_strobe(n);
        check_frame(r0, -1, 6 * CPB + 1);
        wait_strobe(n);
        check("after_rst_latency", n, 1);
        check_frame(r1, -1, -1);
        repeat (5) tick();
        check("rst_strobes", n_strobe - s0, 2);
        check("queue_drained", q_empty, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
